// File: rtl/mux4by16_arb.sv
// Round-robin, packet-locking arbiter in front of a shared 4:1 word mux.
// The granted word lands in a single-entry valid/ready output register.
module mux4by16_arb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [3:0]       req_rot;
    logic [1:0]       win_off;
    logic [1:0]       winner;
    logic             room;
    logic             take;
    logic [WIDTH-1:0] mux_word;

    // Rotate req so bit 0 is the requester at ptr; the first set bit wins.
    always_comb begin
        req_rot = 4'({req, req} >> ptr_q);
        if (req_rot[0])      win_off = 2'd0;
        else if (req_rot[1]) win_off = 2'd1;
        else if (req_rot[2]) win_off = 2'd2;
        else                 win_off = 2'd3;
        winner = ptr_q + win_off;
    end

    always_comb begin
        case (owner_q)
            2'd0:    mux_word = d0;
            2'd1:    mux_word = d1;
            2'd2:    mux_word = d2;
            default: mux_word = d3;
        endcase
    end

    assign room = !out_valid_q || out_ready;
    assign take = (state_q == OWN) && req[owner_q] && room;
    assign gnt  = take ? (4'b0001 << owner_q) : 4'b0000;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (state_q == IDLE) begin
            if (req != 4'b0000) begin
                owner_d = winner;
                state_d = OWN;
            end
        end else if (take && last[owner_q]) begin
            state_d = IDLE;
            ptr_d   = owner_q + 2'd1;
        end

        // Accepting a new word and draining the old one can share an edge.
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_word;
            out_last_d  = last[owner_q];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign sel       = owner_q;
    assign busy      = (state_q == OWN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux4by16_arb.sv
// Directed bench for mux4by16_arb: grants are checked per cycle, and words
// accepted at the output are matched against a queue of expected words.
module tb_mux4by16_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] dv [4];
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [16:0] sbq [$];

    mux4by16_arb #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .last      (last),
        .d0        (dv[0]),
        .d1        (dv[1]),
        .d2        (dv[2]),
        .d3        (dv[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every accepted word must be the oldest expected one.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                logic [16:0] e;
                e = sbq.pop_front();
                chk("sb_data", 32'(out_data), 32'(e[15:0]));
                chk("sb_last", 32'(out_last), 32'(e[16]));
            end
        end
    end

    // One clock of stimulus: the requester expected to be granted sees word w,
    // the others see distinct words, so a wrong select shows up as bad data.
    task automatic step(input logic [3:0] rq, input logic [3:0] lst, input logic ordy,
                        input logic [3:0] eg, input logic [15:0] w);
        int unsigned wi;
        case (eg)
            4'b0010: wi = 1;
            4'b0100: wi = 2;
            4'b1000: wi = 3;
            default: wi = 0;
        endcase
        for (int unsigned k = 0; k < 4; k++)
            dv[k] = (k == wi) ? w : (w ^ (16'h1111 * 16'(k + 1)));
        req       = rq;
        last      = lst;
        out_ready = ordy;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != 4'b0000) sbq.push_back({lst[wi], w});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        for (int unsigned k = 0; k < 4; k++) dv[k] = 16'h5A5A;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-cycle while owning with req=F
        reset_n = 1'b1;
        req     = 4'hF;
        @(posedge clk);
        #1;
        chk("pre_busy", 32'(busy), 32'd1);
        chk("pre_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #1;
        chk("pre_valid", 32'(out_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_data", 32'(out_data), 32'd0);
        chk("async_last", 32'(out_last), 32'd0);
        @(negedge clk);
        chk("async_gnt_low", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        req     = '0;
        reset_n = 1'b1;
        sbq.delete();

        // Single packet from requester 1
        step(4'b0010, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        chk("sp_busy", 32'(busy), 32'd1);
        chk("sp_sel", 32'(sel), 32'd1);
        chk("sp_valid_early", 32'(out_valid), 32'd0);
        step(4'b0010, 4'b0000, 1'b1, 4'b0010, 16'hA001);
        chk("sp_valid", 32'(out_valid), 32'd1);
        chk("sp_first", 32'(out_data), 32'hA001);
        step(4'b0010, 4'b0000, 1'b1, 4'b0010, 16'hA002);
        step(4'b0010, 4'b0010, 1'b1, 4'b0010, 16'hA003);
        chk("sp_busy_fall", 32'(busy), 32'd0);
        chk("sp_out_last", 32'(out_last), 32'd1);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

        // Fairness from ptr=0, every word last
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'hF, 4'hF, 1'b1, 4'b0000, 16'h0000);
            chk("rr_sel", 32'(sel), 32'(i % 4));
            step(4'hF, 4'hF, 1'b1, 4'(1 << (i % 4)), 16'hF000 + 16'(i));
        end
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

        // Backpressure on a 4-word packet from requester 3
        step(4'b1000, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 16'hB001);
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 16'hB002);
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 4'b0000, 1'b0, 4'b0000, 16'hB003);
            chk("bp_hold_data", 32'(out_data), 32'hB002);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 16'hB003);
        step(4'b1000, 4'b1000, 1'b1, 4'b1000, 16'hB004);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

        // Lock: requester 2 owns and drops req while requester 0 waits
        step(4'b0100, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        step(4'b0101, 4'b0000, 1'b1, 4'b0100, 16'hC001);
        step(4'b0001, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        step(4'b0001, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        chk("lock_busy", 32'(busy), 32'd1);
        chk("lock_sel", 32'(sel), 32'd2);
        step(4'b0101, 4'b0000, 1'b1, 4'b0100, 16'hC002);
        step(4'b0101, 4'b0100, 1'b1, 4'b0100, 16'hC003);
        step(4'b0001, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        step(4'b0001, 4'b0001, 1'b1, 4'b0001, 16'hC101);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

        // Reset mid-packet: ptr returns to 0 so requester 0 wins next
        step(4'b0011, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        chk("mid_sel", 32'(sel), 32'd1);
        step(4'b0011, 4'b0000, 1'b1, 4'b0010, 16'hD001);
        #1;
        pulse_reset();
        step(4'b0011, 4'b0000, 1'b1, 4'b0000, 16'h0000);
        chk("post_sel", 32'(sel), 32'd0);
        step(4'b0011, 4'b0001, 1'b1, 4'b0001, 16'hD100);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0000);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4by16_arb.md
# mux4by16_arb

Round-robin, packet-locking arbiter that shares the 16-bit 4:1 word mux among four requesters and registers its output toward one consumer. It owns the mux select. It grants one requester at a time and holds that grant until the requester's last word. The selected word goes into a single-entry output register with a valid/ready handshake. It sits between four word producers and a shared 16-bit sink.

## Interface
- WIDTH, 16, data word width (mux datapath width)
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- req  in  4  req[i]: requester i presents a valid word on d_i
- last  in  4  last[i]: current word of requester i ends its packet
- d0, d1, d2, d3  in  WIDTH  requester data words
- gnt  out  4  one-hot; gnt[i]=1: word on d_i is accepted at this clock edge
- sel  out  2  mux select (owner index), registered
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  output word
- out_last  out  1  out_data is the last word of its packet
- out_ready  in  1  consumer accepts out_data when out_valid&out_ready
- busy  out  1  FSM in OWN

## Operation
- States: IDLE, OWN. Registers: state, owner[1:0] (drives sel), ptr[1:0] (round-robin start), out_valid, out_data, out_last.
- IDLE: if req≠0, pick winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Set owner<=winner and state<=OWN. gnt=0 in IDLE.
- OWN: room = !out_valid | out_ready. gnt[owner] = req[owner] & room; all other gnt bits are 0.
- On gnt: out_data<=mux(d0..d3, sel), out_last<=last[owner], out_valid<=1.
- On gnt with last[owner]=1: state<=IDLE, ptr<=owner+1 (mod 4).
- No gnt and out_ready=1: out_valid<=0.
- Lock: if req[owner] drops in OWN, the block stays in OWN with gnt=0. Other requesters wait until the owner's last word. There is no timeout.
- out_data and out_last hold while out_valid=1 & out_ready=0.
- Unselected requesters' d/last are ignored. req may change freely in IDLE.
- Reset values: state=IDLE, owner/sel=0, ptr=0, out_valid=0, out_data=0, out_last=0, busy=0, gnt=0.
- reset_n low clears all of the above immediately, mid-packet included. A partially transferred packet is abandoned and is not resumed.

## Timing
- Cycle n: IDLE samples req≠0. Cycle n+1: OWN, sel valid, gnt combinational from req/out_ready. Cycle n+2: out_valid=1 with first word.
- Within a packet, throughput is 1 word/cycle with out_ready held high.
- After a last-word gnt there is exactly one IDLE cycle (arbitration bubble) before the next grant. Minimum packet-to-packet gap at gnt is 2 cycles.
- gnt depends combinationally on req, out_valid, out_ready, owner and state. It has no path from d*.
- The output register behaves like a pipeline register: a word is accepted while the previous one drains on the same edge (out_valid&out_ready&gnt).
- At most one gnt bit is set in any cycle. sel changes only on the IDLE→OWN edge.

## Test plan
- Reset: drive reset_n=0 with req=4'hF asynchronously mid-cycle -> all outputs 0 immediately, and gnt=0 while reset is low.
- Single packet: req=4'b0010, d1 = 16'hA001, A002, A003, last on third, out_ready=1 -> sel=1; out_data A001/A002/A003 on three consecutive cycles starting 2 cycles after req; out_last only with A003; busy falls after the A003 gnt.
- Fairness: req=4'hF continuously, every word last, out_ready=1 -> grant order 0,1,2,3,0,1.
- Backpressure: 4-word packet from requester 3, out_ready=0 for 3 cycles after word 2 is accepted -> out_data stays at word 2, gnt=0 during the stall, words 3 and 4 follow in order, nothing dropped or duplicated.
- Lock: requester 2 owns, drops req for 2 cycles mid-packet while req[0]=1 -> gnt[0] stays 0; requester 2 resumes and finishes; then requester 0 is granted after the IDLE cycle.
- Reset mid-packet: reset_n pulsed low during requester 1's packet with req=4'b0011 -> after release, the first grant goes to requester 0 (ptr=0) with a 2-cycle arbitration latency.
